// File: rtl/mem_arbiter.sv
// Shares one memory port between a read-only fetch client (I) and a read/write data client (D).
// Latency: request seen in IDLE at cycle t reaches memory at t+1; resp is combinational from mem_resp.
// Backpressure: clients hold requests until resp; one IDLE bubble follows every completed access.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        grant_d
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

  state_t     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       d_req;
  logic       force_i;

  assign d_req   = d_read | d_write;
  // Fetch has waited through the allowed number of data grants: it wins this round.
  assign force_i = i_read && (streak_q == MaxStreak);

  // State and anti-starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Arbitration happens only in IDLE; serve states wait for mem_resp.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (d_req && !force_i) begin
          state_d = SERVE_D;
          if (i_read) begin
            streak_d = (streak_q == MaxStreak) ? streak_q : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end else if (i_read) begin
          state_d  = SERVE_I;
          streak_d = 4'd0;
        end else begin
          streak_d = 4'd0;
        end
      end
      SERVE_I: if (mem_resp) state_d = IDLE;
      SERVE_D: if (mem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port and response steering from the granted client's held inputs.
  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b0000;
    mem_address     = 32'h0;
    mem_wdata       = 32'h0;
    i_resp          = 1'b0;
    i_rdata         = 32'h0;
    d_resp          = 1'b0;
    d_rdata         = 32'h0;
    grant_d         = 1'b0;
    case (state_q)
      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        i_resp      = mem_resp;
        i_rdata     = mem_resp ? mem_rdata : 32'h0;
      end
      SERVE_D: begin
        // A simultaneous read and write is treated as a write.
        mem_read        = d_read & ~d_write;
        mem_write       = d_write;
        mem_byte_enable = d_byte_enable;
        mem_address     = d_address;
        mem_wdata       = d_wdata;
        d_resp          = mem_resp;
        d_rdata         = mem_resp ? mem_rdata : 32'h0;
        grant_d         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
